// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: write-side controller of the 32x32 register file.
// ALU results always win the single write port; load responses wait in a
// small FIFO and drain on cycles the ALU leaves idle. A busy scoreboard marks
// registers with an outstanding load so issue logic can stall RAW/WAW hazards.
// Optional macro RFWB_FWD_EN enables the write-port forwarding outputs;
// without it the fwd* ports exist but are tied to zero.
//
// Load response handshake: a response transfers on a rising edge where
// ld_valid and ld_ready are both high; ld_ready does not depend on ld_valid.
module rf_writeback_ctrl #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wd,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam logic [PW:0]   DEPTH_C = LQ_DEPTH[PW:0];
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [4:0]      q_rd   [LQ_DEPTH];
    logic [XLEN-1:0] q_data [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            active;     // low until the first edge after reset release
    logic            rf_is_ld;   // current rf_we write came from the load FIFO
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic            sel_alu;
    logic            pop;
    logic            push;

    // Write-port selection and load-queue handshake for this cycle
    always_comb begin
        sel_alu  = alu_valid & (alu_rd != 5'd0);
        pop      = ~sel_alu & (count != '0);
        ld_ready = active & ((count < DEPTH_C) | ((count == DEPTH_C) & pop));
        push     = ld_valid & ld_ready & (ld_rd != 5'd0);
    end

    // Load FIFO storage; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= ld_rd;
            q_data[wr_ptr] <= ld_data;
        end
    end

    // Load FIFO pointers, occupancy and post-reset enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push & ~pop)      count <= count + CNT_ONE;
            else if (pop & ~push) count <= count - CNT_ONE;
        end
    end

    // Registered RF write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= 5'd0;
            rf_wd    <= '0;
            rf_is_ld <= 1'b0;
        end else begin
            rf_we    <= sel_alu | pop;
            rf_is_ld <= pop;
            if (sel_alu) begin
                rf_rd <= alu_rd;
                rf_wd <= alu_data;
            end else if (pop) begin
                rf_rd <= q_rd[rd_ptr];
                rf_wd <= q_data[rd_ptr];
            end else begin
                rf_rd <= 5'd0;
                rf_wd <= '0;
            end
        end
    end

    // Scoreboard next state: clear on RF capture of a load, then set on issue
    always_comb begin
        busy_nxt = busy;
        if (rf_we & rf_is_ld) busy_nxt[rf_rd] = 1'b0;
        if (iss_valid & (iss_rd != 5'd0)) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign rs1_busy = (rs1 != 5'd0) & busy[rs1];
    assign rs2_busy = (rs2 != 5'd0) & busy[rs2];

`ifdef RFWB_FWD_EN
    // Cover the cycle between rf_we and the RF actually capturing the data
    assign fwd1_hit  = rf_we & (rf_rd == rs1) & (rs1 != 5'd0);
    assign fwd2_hit  = rf_we & (rf_rd == rs2) & (rs2 != 5'd0);
    assign fwd1_data = rf_wd;
    assign fwd2_data = rf_wd;
`else
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios followed by random traffic,
// checked against a write-port scoreboard and a behavioural FIFO/busy model.
module tb_rf_writeback_ctrl;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;

    int checks   = 0;
    int failures = 0;

    logic [37:0] exp_q[$];   // {from_load, rd, data} expected on rf_* next cycle
    logic [36:0] mq[$];      // model load FIFO {rd, data}
    logic [31:0] m_busy;
    logic        m_acc;

    rf_writeback_ctrl #(.XLEN(XLEN), .LQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = '0;
        iss_valid = 1'b0; iss_rd = 5'd0;
    endtask

    // One clock: compare outputs at the falling edge, advance the model with
    // the inputs being presented, then step past the rising edge.
    task automatic tick();
        logic [37:0] head;
        logic        has;
        logic        sel_alu;
        logic        pop;
        logic        m_ready;
        logic        h1;
        logic        h2;
        head = '0;
        @(negedge clk);
        has = (exp_q.size() != 0);
        check("rf_we", {63'd0, rf_we}, {63'd0, has});
        if (has) begin
            head = exp_q.pop_front();
            if (rf_we) begin
                check("rf_rd", {59'd0, rf_rd}, {59'd0, head[36:32]});
                check("rf_wd", {32'd0, rf_wd}, {32'd0, head[31:0]});
            end
        end
`ifdef RFWB_FWD_EN
        h1 = has && (rs1 != 5'd0) && (head[36:32] == rs1);
        h2 = has && (rs2 != 5'd0) && (head[36:32] == rs2);
        check("fwd1_hit", {63'd0, fwd1_hit}, {63'd0, h1});
        check("fwd2_hit", {63'd0, fwd2_hit}, {63'd0, h2});
        if (h1) check("fwd1_data", {32'd0, fwd1_data}, {32'd0, head[31:0]});
        if (h2) check("fwd2_data", {32'd0, fwd2_data}, {32'd0, head[31:0]});
`else
        h1 = 1'b0;
        h2 = 1'b0;
        check("fwd1_hit", {63'd0, fwd1_hit}, {63'd0, h1});
        check("fwd2_hit", {63'd0, fwd2_hit}, {63'd0, h2});
        check("fwd_data", {fwd1_data, fwd2_data}, 64'd0);
`endif
        check("rs1_busy", {63'd0, rs1_busy}, {63'd0, (rs1 != 5'd0) && m_busy[rs1]});
        check("rs2_busy", {63'd0, rs2_busy}, {63'd0, (rs2 != 5'd0) && m_busy[rs2]});
        sel_alu = alu_valid && (alu_rd != 5'd0);
        pop     = !sel_alu && (mq.size() != 0);
        m_ready = (mq.size() < DEPTH) || ((mq.size() == DEPTH) && pop);
        check("ld_ready", {63'd0, ld_ready}, {63'd0, m_ready});
        m_acc = ld_valid && m_ready;
        if (has && head[37]) m_busy[head[36:32]] = 1'b0;
        if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (sel_alu)  exp_q.push_back({1'b0, alu_rd, alu_data});
        else if (pop) exp_q.push_back({1'b1, mq.pop_front()});
        if (m_acc && ld_rd != 5'd0) mq.push_back({ld_rd, ld_data});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        exp_q.delete();
        mq.delete();
        m_busy = '0;
        m_acc  = 1'b0;
    endtask

    initial begin
        int k;
        logic [4:0] r;
        reset_model();
        idle();
        rs1 = 5'd0; rs2 = 5'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rf_we", {63'd0, rf_we}, 64'd0);
        check("rst_rf_rd", {59'd0, rf_rd}, 64'd0);
        check("rst_rf_wd", {32'd0, rf_wd}, 64'd0);
        check("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        idle();
        tick();
        tick();

        // T2: issue x7, load response three cycles later
        rs1 = 5'd7; rs2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        idle();
        tick();
        tick();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        tick();
        idle();
        repeat (4) tick();
        check("t2_busy_clear", {63'd0, rs1_busy}, 64'd0);

        // T3: ALU every cycle starves a stream of 5 load responses
        k = 0;
        for (int c = 0; c < 10; c++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + c % 5); alu_data = 32'hA000 + c;
            ld_valid = (k < 5); ld_rd = 5'(20 + k); ld_data = 32'h1000 + k;
            tick();
            if (m_acc) k++;
        end
        check("t3_accepted", k, 4);
        alu_valid = 1'b0;
        while (k < 5) begin
            ld_valid = 1'b1; ld_rd = 5'(20 + k); ld_data = 32'h1000 + k;
            tick();
            if (m_acc) k++;
        end
        idle();
        repeat (7) tick();

        // T4: writes to x0 are suppressed, load to x0 is discarded
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h5555;
        tick();
        idle();
        repeat (3) tick();

        // T5: reset with 3 queued loads and 2 busy registers
        rs1 = 5'd3; rs2 = 5'd4;
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_rd = 5'd4;
        tick();
        iss_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0 + c;
            ld_valid = 1'b1; ld_rd = 5'(3 + c); ld_data = 32'hB0 + c;
            tick();
        end
        ld_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rf_we", {63'd0, rf_we}, 64'd0);
        check("t5_rs1_busy", {63'd0, rs1_busy}, 64'd0);
        check("t5_rs2_busy", {63'd0, rs2_busy}, 64'd0);
        check("t5_ld_ready", {63'd0, ld_ready}, 64'd0);
        reset_model();
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (6) tick();

        // T6: forwarding view of the write port
        rs1 = 5'd0; rs2 = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA5A5A5A5;
        tick();
        idle();
        tick();
        rs2 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h5A5A5A5A;
        tick();
        idle();
        tick();

        // Random traffic respecting the no-issue/no-write-to-busy rule
        for (int c = 0; c < 400; c++) begin
            r = 5'($urandom_range(0, 31));
            alu_valid = ($urandom_range(0, 2) == 0);
            alu_rd    = m_busy[r] ? 5'd0 : r;
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 1) == 1);
            ld_rd     = 5'($urandom_range(0, 31));
            ld_data   = $urandom;
            r = 5'($urandom_range(0, 31));
            iss_valid = ($urandom_range(0, 3) == 0) && !m_busy[r];
            iss_rd    = r;
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
